// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction fetch stage with a single IF/ID pipeline register
//
// Fetches instructions sequentially from an instruction memory and loads them
// into the IF/ID register. A decode stall that arrives while a fetch completes
// parks the returned word in a one-entry hold buffer. A branch redirect
// flushes the IF/ID register and the hold buffer.
//
// Parameters:
//   XLEN      PC / address width in bits (>= 8)
//   RESET_PC  PC after reset (bits [1:0] must be 0)
//   PC_STEP   sequential PC increment
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-low reset
//   start_i      in   run enable, only looked at in IDLE
//   stall_i      in   decode stall, holds the IF/ID register
//   branch_i     in   one-cycle redirect request
//   target_i     in   redirect target PC
//   imem_req_o   out  instruction memory request (level)
//   imem_addr_o  out  fetch address
//   imem_ack_i   in   data valid for the address presented this cycle
//   imem_data_i  in   fetched instruction word
//   id_valid_o   out  IF/ID holds a valid instruction
//   id_pc_o      out  PC of the IF/ID instruction
//   id_pc4_o     out  id_pc_o + PC_STEP
//   id_instr_o   out  IF/ID instruction
//   fetch_cnt_o  out  number of instructions loaded into IF/ID
// ============================================================================
module if_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               PC_STEP  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc4_o,
    output logic [31:0]     id_instr_o,
    output logic [31:0]     fetch_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc4_q, id_pc4_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic [31:0]     hold_q, hold_d;
    logic            load_en;
    logic [31:0]     load_word;

    // Redirect targets are forced word-aligned, so the low bits are dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^target_i[1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_pc4_q    <= '0;
            id_instr_q  <= '0;
            fetch_cnt_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
            id_instr_q  <= id_instr_d;
            fetch_cnt_q <= fetch_cnt_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_pc4_d    = id_pc4_q;
        id_instr_d  = id_instr_q;
        fetch_cnt_d = fetch_cnt_q;
        hold_d      = hold_q;
        load_en     = 1'b0;
        load_word   = imem_data_i;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                end
                if (!stall_i) begin
                    id_valid_d = 1'b0;
                end
            end

            FETCH: begin
                if (branch_i) begin
                    // Redirect wins over a same-cycle ack; that word is dropped.
                    pc_d       = {target_i[XLEN-1:2], 2'b00};
                    id_valid_d = 1'b0;
                    hold_d     = '0;
                    state_d    = FETCH;
                end else if (imem_ack_i) begin
                    if (!id_valid_q || !stall_i) begin
                        load_en   = 1'b1;
                        load_word = imem_data_i;
                    end else begin
                        // IF/ID occupied and stalled: park the word.
                        hold_d  = imem_data_i;
                        state_d = HOLD;
                    end
                end else if (!stall_i) begin
                    id_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (branch_i) begin
                    pc_d       = {target_i[XLEN-1:2], 2'b00};
                    id_valid_d = 1'b0;
                    hold_d     = '0;
                    state_d    = FETCH;
                end else if (!stall_i) begin
                    load_en   = 1'b1;
                    load_word = hold_q;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // PC of the loaded word is the current PC in both FETCH and HOLD,
        // since the PC only advances once the word reaches IF/ID.
        if (load_en) begin
            id_valid_d  = 1'b1;
            id_pc_d     = pc_q;
            id_pc4_d    = pc_q + STEP;
            id_instr_d  = load_word;
            pc_d        = pc_q + STEP;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    assign imem_req_o  = (state_q == FETCH);
    assign imem_addr_o = pc_q;
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_pc4_o    = id_pc4_q;
    assign id_instr_o  = id_instr_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule
